// File: rtl/mem_handshake_bridge_pkg.sv
// Shared types and constants for the memory handshake bridge and its channel FSMs.
package mem_handshake_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACC  = 2'd2,
        ST_RESP = 2'd3
    } chan_state_t;

    localparam int DELAY_CNT_W = 4;

    // Memory ports carry word indices: byte address without its two low bits.
    function automatic int word_idx_w(input int addr_width);
        return addr_width - 2;
    endfunction

endpackage

// File: rtl/mem_chan_fsm.sv
// One valid/ready channel: request delay counter, handshake FSM and registered read response.
module mem_chan_fsm
    import mem_handshake_bridge_pkg::*;
#(
    parameter int REQ_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic        i_write,
    input  logic [31:0] i_rdata,
    input  logic        i_rsp_ready,
    output logic        o_req_ready,
    output logic        o_acc,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data
);

    chan_state_t            r_state;
    logic [DELAY_CNT_W-1:0] r_cnt;
    logic                   r_req_ready;
    logic                   r_rsp_valid;
    logic [31:0]            r_rsp_data;

    // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_req_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        if (REQ_DELAY == 0) begin
                            r_state     <= ST_ACC;
                            r_req_ready <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= DELAY_CNT_W'(REQ_DELAY);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!i_req) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DELAY_CNT_W'(1)) begin
                        r_state     <= ST_ACC;
                        r_cnt       <= '0;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_ACC: begin
                    // The memory read is asynchronous, so the word is captured at the accepting edge.
                    if (i_write) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= i_rdata;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_acc       = (r_state == ST_ACC);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;

endmodule

// File: rtl/mem_handshake_bridge.sv
// Converts the core's valid/ready instruction and data channels into flat ideal-memory strobes.
module mem_handshake_bridge
    import mem_handshake_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int REQ_DELAY  = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              Inst_Req_Valid,
    output logic                              Inst_Req_Ready,
    input  logic [31:0]                       PC,
    output logic [31:0]                       Instruction,
    output logic                              Inst_Valid,
    input  logic                              Inst_Ready,
    input  logic [31:0]                       Address,
    input  logic                              MemWrite,
    input  logic                              MemRead,
    input  logic [31:0]                       Write_data,
    input  logic [3:0]                        Write_strb,
    output logic                              Mem_Req_Ready,
    output logic [31:0]                       Read_data,
    output logic                              Read_data_Valid,
    input  logic                              Read_data_Ready,
    output logic [word_idx_w(ADDR_WIDTH)-1:0] mem_Raddr1,
    output logic [word_idx_w(ADDR_WIDTH)-1:0] mem_Raddr2,
    output logic [word_idx_w(ADDR_WIDTH)-1:0] mem_Waddr,
    output logic                              mem_Rden1,
    output logic                              mem_Rden2,
    output logic                              mem_Wren,
    output logic [31:0]                       mem_Wdata,
    output logic [3:0]                        mem_Wstrb,
    input  logic [31:0]                       mem_Rdata1,
    input  logic [31:0]                       mem_Rdata2
);

    logic w_inst_acc;
    logic w_data_acc;
    logic w_data_req;
    logic w_unused_addr;

    assign w_data_req = MemRead | MemWrite;

    mem_chan_fsm #(.REQ_DELAY(REQ_DELAY)) u_inst_chan (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (Inst_Req_Valid),
        .i_write     (1'b0),
        .i_rdata     (mem_Rdata1),
        .i_rsp_ready (Inst_Ready),
        .o_req_ready (Inst_Req_Ready),
        .o_acc       (w_inst_acc),
        .o_rsp_valid (Inst_Valid),
        .o_rsp_data  (Instruction)
    );

    // A combined read+write request is a write: the write flag wins inside the FSM and here.
    mem_chan_fsm #(.REQ_DELAY(REQ_DELAY)) u_data_chan (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (w_data_req),
        .i_write     (MemWrite),
        .i_rdata     (mem_Rdata2),
        .i_rsp_ready (Read_data_Ready),
        .o_req_ready (Mem_Req_Ready),
        .o_acc       (w_data_acc),
        .o_rsp_valid (Read_data_Valid),
        .o_rsp_data  (Read_data)
    );

    assign mem_Rden1  = w_inst_acc;
    assign mem_Rden2  = w_data_acc & ~MemWrite;
    assign mem_Wren   = w_data_acc & MemWrite;

    assign mem_Raddr1 = PC[ADDR_WIDTH-1:2];
    assign mem_Raddr2 = Address[ADDR_WIDTH-1:2];
    assign mem_Waddr  = Address[ADDR_WIDTH-1:2];
    assign mem_Wdata  = Write_data;
    assign mem_Wstrb  = Write_strb;

    // Address bits outside the word index wrap away by truncation.
    assign w_unused_addr = ^{PC[31:ADDR_WIDTH], PC[1:0], Address[31:ADDR_WIDTH], Address[1:0]};

endmodule

// File: tb/tb_mem_handshake_bridge.sv
// Bench for mem_handshake_bridge: two instances (REQ_DELAY 2 and 0), each on its own ideal memory.
module tb_mem_handshake_bridge;

    localparam int AW    = 14;
    localparam int WW    = AW - 2;
    localparam int DEPTH = 1 << WW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          inst_req_valid [2], inst_req_ready [2], inst_valid [2], inst_ready [2];
    logic          mem_write [2], mem_read [2], mem_req_ready [2], rd_valid [2], rd_ready [2];
    logic          mem_rden1 [2], mem_rden2 [2], mem_wren [2];
    logic [31:0]   pc_in [2], instruction [2], address [2], write_data [2], read_data [2];
    logic [31:0]   mem_wdata [2], mem_rdata1 [2], mem_rdata2 [2];
    logic [3:0]    write_strb [2], mem_wstrb [2];
    logic [WW-1:0] mem_raddr1 [2], mem_raddr2 [2], mem_waddr [2];

    logic [31:0] mem [2][DEPTH];
    logic [31:0] model_mem [2][DEPTH];
    logic        mem_clr = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_handshake_bridge #(.ADDR_WIDTH(AW), .REQ_DELAY(g == 0 ? 2 : 0)) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .Inst_Req_Valid  (inst_req_valid[g]),
            .Inst_Req_Ready  (inst_req_ready[g]),
            .PC              (pc_in[g]),
            .Instruction     (instruction[g]),
            .Inst_Valid      (inst_valid[g]),
            .Inst_Ready      (inst_ready[g]),
            .Address         (address[g]),
            .MemWrite        (mem_write[g]),
            .MemRead         (mem_read[g]),
            .Write_data      (write_data[g]),
            .Write_strb      (write_strb[g]),
            .Mem_Req_Ready   (mem_req_ready[g]),
            .Read_data       (read_data[g]),
            .Read_data_Valid (rd_valid[g]),
            .Read_data_Ready (rd_ready[g]),
            .mem_Raddr1      (mem_raddr1[g]),
            .mem_Raddr2      (mem_raddr2[g]),
            .mem_Waddr       (mem_waddr[g]),
            .mem_Rden1       (mem_rden1[g]),
            .mem_Rden2       (mem_rden2[g]),
            .mem_Wren        (mem_wren[g]),
            .mem_Wdata       (mem_wdata[g]),
            .mem_Wstrb       (mem_wstrb[g]),
            .mem_Rdata1      (mem_rdata1[g]),
            .mem_Rdata2      (mem_rdata2[g])
        );
        assign mem_rdata1[g] = mem[g][mem_raddr1[g]];
        assign mem_rdata2[g] = mem[g][mem_raddr2[g]];
    end

    function automatic logic [31:0] merge_strb(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic int delay_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Ideal memory: asynchronous read, byte-strobed write committed at the clock edge.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_clr) begin
                for (int i = 0; i < DEPTH; i++) mem[d][i] <= '0;
            end else if (mem_wren[d]) begin
                mem[d][mem_waddr[d]] <= merge_strb(mem[d][mem_waddr[d]], mem_wdata[d], mem_wstrb[d]);
            end
        end
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @%0t: observed %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @%0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input int d);
        check1("rst inst_req_ready", inst_req_ready[d], 1'b0);
        check1("rst inst_valid", inst_valid[d], 1'b0);
        check32("rst instruction", instruction[d], 32'h0);
        check1("rst mem_req_ready", mem_req_ready[d], 1'b0);
        check1("rst read_data_valid", rd_valid[d], 1'b0);
        check32("rst read_data", read_data[d], 32'h0);
        check1("rst rden1", mem_rden1[d], 1'b0);
        check1("rst rden2", mem_rden2[d], 1'b0);
        check1("rst wren", mem_wren[d], 1'b0);
    endtask

    // Runs one transaction per enabled channel, both starting in cycle 0 (entered just after a posedge).
    // Expected timing: accept in cycle REQ_DELAY+1, response valid from the next cycle until ready.
    task automatic run_txn(input int d,
                           input bit do_i, input logic [31:0] pc, input int hold_i,
                           input bit do_d, input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] strb, input int hold_d);
        int          acc;
        int          last;
        bit          rd_only;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
        acc     = delay_of(d) + 1;
        last    = acc + 2 + ((hold_i > hold_d) ? hold_i : hold_d);
        rd_only = do_d && rd && !wr;
        exp_i   = model_mem[d][pc[AW-1:2]];
        exp_d   = model_mem[d][addr[AW-1:2]];
        for (int c = 0; c <= last; c++) begin
            inst_req_valid[d] = do_i && (c <= acc);
            pc_in[d]          = pc;
            mem_write[d]      = do_d && wr && (c <= acc);
            mem_read[d]       = do_d && rd && (c <= acc);
            address[d]        = addr;
            write_data[d]     = wd;
            write_strb[d]     = strb;
            inst_ready[d]     = (c >= acc + 1 + hold_i);
            rd_ready[d]       = (c >= acc + 1 + hold_d);
            @(negedge clk);
            check1("inst_req_ready", inst_req_ready[d], do_i && (c == acc));
            check1("mem_rden1", mem_rden1[d], do_i && (c == acc));
            check1("mem_req_ready", mem_req_ready[d], do_d && (c == acc));
            check1("mem_rden2", mem_rden2[d], rd_only && (c == acc));
            check1("mem_wren", mem_wren[d], do_d && wr && (c == acc));
            check1("inst_valid", inst_valid[d], do_i && (c >= acc + 1) && (c <= acc + 1 + hold_i));
            check1("read_data_valid", rd_valid[d], rd_only && (c >= acc + 1) && (c <= acc + 1 + hold_d));
            if (do_i && (c >= acc + 1) && (c <= acc + 1 + hold_i))
                check32("instruction", instruction[d], exp_i);
            if (rd_only && (c >= acc + 1) && (c <= acc + 1 + hold_d))
                check32("read_data", read_data[d], exp_d);
            if (c == acc && do_i)
                check32("mem_raddr1", 32'(mem_raddr1[d]), 32'(pc[AW-1:2]));
            if (c == acc && do_d) begin
                check32("mem_raddr2", 32'(mem_raddr2[d]), 32'(addr[AW-1:2]));
                check32("mem_waddr", 32'(mem_waddr[d]), 32'(addr[AW-1:2]));
                check32("mem_wdata", mem_wdata[d], wd);
                check32("mem_wstrb", 32'(mem_wstrb[d]), 32'(strb));
            end
            @(posedge clk);
            #1;
        end
        if (do_d && wr)
            model_mem[d][addr[AW-1:2]] = merge_strb(model_mem[d][addr[AW-1:2]], wd, strb);
        inst_ready[d] = 1'b0;
        rd_ready[d]   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            inst_req_valid[d] = 1'b0; inst_ready[d] = 1'b0; pc_in[d] = '0;
            mem_write[d] = 1'b0; mem_read[d] = 1'b0; rd_ready[d] = 1'b0;
            address[d] = '0; write_data[d] = '0; write_strb[d] = '0;
            for (int i = 0; i < DEPTH; i++) model_mem[d][i] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_idle_outputs(d);
        mem_clr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Preload words 0x10 and 0x11 through the data write path
        for (int d = 0; d < 2; d++) begin
            run_txn(d, 0, 0, 0, 1, 1, 0, 32'h40, 32'hDEADBEEF, 4'hF, 0);
            run_txn(d, 0, 0, 0, 1, 1, 0, 32'h44, 32'hAABBCCDD, 4'hF, 0);
        end

        // Fetch with Inst_Ready held low for 5 response cycles
        run_txn(0, 1, 32'h40, 5, 0, 0, 0, 0, 0, 4'h0, 0);

        // Partial-strobe write, then zero-delay read of the merged word
        for (int d = 0; d < 2; d++) begin
            run_txn(d, 0, 0, 0, 1, 1, 0, 32'h44, 32'h11223344, 4'b0101, 0);
            check32("merged word", mem[d][12'h11], 32'hAA22CC44);
        end
        run_txn(1, 0, 0, 0, 1, 0, 1, 32'h44, 0, 4'h0, 1);

        // Same-word fetch and write accepted together: fetch sees the old word
        run_txn(0, 1, 32'h44, 1, 1, 1, 0, 32'h44, 32'h55667788, 4'hF, 0);
        check32("write after collide", mem[0][12'h11], 32'h55667788);

        // Reset while a write waits out its delay
        address[0] = 32'h48; write_data[0] = 32'hCAFEF00D; write_strb[0] = 4'hF; mem_write[0] = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs(0);
        mem_write[0] = 1'b0;
        @(negedge clk);
        check1("wren in reset", mem_wren[0], 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check1("wren after reset", mem_wren[0], 1'b0);
            check1("req_ready after reset", mem_req_ready[0], 1'b0);
            @(posedge clk);
            #1;
        end
        check32("word untouched", mem[0][12'h12], model_mem[0][12'h12]);
        run_txn(0, 0, 0, 0, 1, 0, 1, 32'h40, 0, 4'h0, 0);

        // Read abandoned while waiting
        address[0] = 32'h44; mem_read[0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) mem_read[0] = 1'b0;
            @(negedge clk);
            check1("abandon req_ready", mem_req_ready[0], 1'b0);
            check1("abandon rden2", mem_rden2[0], 1'b0);
            check1("abandon rd_valid", rd_valid[0], 1'b0);
            @(posedge clk);
            #1;
        end

        // Random transactions over a small word window with junk upper and low address bits
        for (int n = 0; n < 40; n++) begin
            int          d;
            bit          di, dd, wr, rd;
            logic [31:0] pc, ad, wd;
            logic [3:0]  st;
            d  = int'($urandom_range(1, 0));
            di = 1'($urandom_range(1, 0));
            dd = 1'($urandom_range(1, 0));
            wr = 1'($urandom_range(1, 0));
            rd = 1'($urandom_range(1, 0));
            if (!di && !dd) dd = 1'b1;
            if (!wr && !rd) rd = 1'b1;
            pc = ($urandom & 32'hFFFF_C003) | (32'(16 + $urandom_range(7, 0)) << 2);
            ad = ($urandom & 32'hFFFF_C003) | (32'(16 + $urandom_range(7, 0)) << 2);
            wd = $urandom;
            st = 4'($urandom_range(15, 0));
            run_txn(d, di, pc, int'($urandom_range(3, 0)), dd, wr, rd, ad, wd, st,
                    int'($urandom_range(3, 0)));
        end
        for (int i = 16; i < 24; i++) begin
            check32("final mem d0", mem[0][i], model_mem[0][i]);
            check32("final mem d1", mem[1][i], model_mem[1][i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_handshake_bridge.md
Name: mem_handshake_bridge

Overview:
- Sits directly upstream of the ideal memory and converts the CPU core's valid/ready instruction and data channels into the memory's flat single-cycle port signals.
- Inserts a programmable request latency so handshake-tolerant CPU logic is exercised against the ideal memory.
- Registers read responses until the core accepts them.
- Two independent channels:
  - instruction: read-only, uses memory read port 1.
  - data: read/write, uses read port 2 and the write port.

Parameters:
ADDR_WIDTH, 14, byte-address width of memory; word index is bits [ADDR_WIDTH-1:2]
REQ_DELAY, 2, extra wait cycles before Req_Ready is raised (0..15)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
Inst_Req_Valid  in  1  instruction fetch request
Inst_Req_Ready  out  1  fetch request accepted (registered)
PC  in  32  fetch byte address
Instruction  out  32  registered fetched word
Inst_Valid  out  1  Instruction valid
Inst_Ready  in  1  core accepts Instruction
Address  in  32  data byte address
MemWrite  in  1  data write request
MemRead  in  1  data read request
Write_data  in  32  store data
Write_strb  in  4  byte enables
Mem_Req_Ready  out  1  data request accepted (registered)
Read_data  out  32  registered load word
Read_data_Valid  out  1  Read_data valid
Read_data_Ready  in  1  core accepts Read_data
mem_Raddr1  out  ADDR_WIDTH-2  = PC[ADDR_WIDTH-1:2]
mem_Raddr2  out  ADDR_WIDTH-2  = Address[ADDR_WIDTH-1:2]
mem_Waddr  out  ADDR_WIDTH-2  = Address[ADDR_WIDTH-1:2]
mem_Rden1  out  1  read enable port 1
mem_Rden2  out  1  read enable port 2
mem_Wren  out  1  write enable
mem_Wdata  out  32  = Write_data
mem_Wstrb  out  4  = Write_strb
mem_Rdata1  in  32  memory read data 1
mem_Rdata2  in  32  memory read data 2

Behaviour:
- Each channel runs its own FSM: IDLE -> WAIT -> ACC -> RESP -> IDLE.
  - The data channel's request is "req" = MemRead | MemWrite.
- IDLE: on req sampled high, go to WAIT with cnt=REQ_DELAY, or straight to ACC if REQ_DELAY=0.
- WAIT: decrement cnt each cycle. At cnt=1, go to ACC. If req drops, return to IDLE (abandoned request, nothing issued).
- ACC:
  - *_Req_Ready=1 for exactly one cycle, and the handshake completes that cycle.
  - Req_Ready first rises REQ_DELAY+1 cycles after req is first sampled.
  - Read (inst, or MemRead&~MemWrite): Rden=1 combinationally in ACC. At the ACC clock edge, latch mem_Rdata into the response register, set *_Valid=1, go to RESP.
  - Write (MemWrite): mem_Wren=1 combinationally in ACC so memory commits at the ACC edge; go to IDLE with no response.
  - MemWrite&MemRead together is treated as a write.
- RESP: *_Valid held at 1 and data held stable until *_Ready. On the Valid&Ready cycle, clear Valid and go to IDLE. A new request is sampled no earlier than the next cycle.
- Rden/Wren are 0 in every state other than ACC.
- Address and data passthroughs are combinational and unconditioned.
- Channels are independent: both may be in ACC the same cycle.
  - Same-word data write and instruction fetch in the same ACC cycle: the instruction returns the OLD word, since the asynchronous read is latched at the edge that commits the write.
- Reset (async, any state):
  - FSMs to IDLE, cnt=0.
  - Req_Ready, Valid, Rden, Wren = 0; Instruction and Read_data = 0.
  - An in-flight request is dropped and no write is issued.
- Upper address bits above ADDR_WIDTH-1 and bits [1:0] are ignored (word wrap-around by truncation).

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE/WAIT/ACC/RESP, 2 bits);
  - DELAY_CNT_W=4;
  - the word-index width helper ADDR_WIDTH-2.
- One natural sub-module, mem_chan_fsm: counter, FSM, response register, and the ACC strobe.
  - It is instantiated twice; the data instance uses the write flag, the instruction instance ties it to 0.

Test Plan:
- REQ_DELAY=2, mem[0x10]=0xDEADBEEF, Inst_Req_Valid at cycle 0 with PC=0x40:
  - Inst_Req_Ready high only at cycle 3.
  - Instruction=0xDEADBEEF with Inst_Valid high from cycle 4.
  - With Inst_Ready held low 5 cycles, Valid and data stay stable; Valid clears the cycle after Inst_Ready.
- MemWrite with Address=0x44, Write_data=0x11223344, Write_strb=4'b0101 over old 0xAABBCCDD:
  - mem_Wren high exactly one cycle (ACC).
  - Memory word becomes 0xAA22CC44.
  - No Read_data_Valid.
- REQ_DELAY=0 MemRead Address=0x44: Mem_Req_Ready the cycle after request, Read_data=0xAA22CC44 the next cycle.
- Inst fetch and data write both to word 0x11, reaching ACC simultaneously: Instruction returns the pre-write value; the memory holds the new value.
- rst_n pulled low while the data channel is in WAIT on a write:
  - all outputs 0 immediately;
  - no mem_Wren ever asserted;
  - after release, a new read completes normally.
- MemRead dropped in WAIT: FSM returns to IDLE, Mem_Req_Ready never asserts, mem_Rden2 stays 0.
